pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Registered program-counter stage that owns the fetch address.
- Computes branch, jump, jump-register and ERET targets, and holds the PC under pipeline stall.
- Buffers a redirect that arrives during a stall and applies it once the stall releases.
- Sits between IF and ID. ID supplies the resolved redirect, and the CP0/exception unit supplies the exception redirect and EPC.

Parameters:
WIDTH, 32, PC/address width (>= 28)
RESET_VECTOR, 32'hBFC0_0000, PC value after reset
EXC_VECTOR, 32'hBFC0_0380, PC loaded on exception
DELAY_SLOT, 1, 1 = MIPS branch delay slot honoured; 0 = the instruction fetched alongside a redirect is squashed

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
stall  in  1  hold PC (IF/ID stalled)
redir_valid  in  1  taken redirect resolved in ID this cycle
redir_kind  in  2  0 BRANCH, 1 JUMP, 2 JREG, 3 ERET
redir_base  in  WIDTH  PC+4 of the branch/jump instruction (delay-slot address)
imm26  in  26  instruction immediate field
reg_target  in  WIDTH  rs value for JREG
epc  in  WIDTH  return address for ERET
exc_valid  in  1  exception redirect, highest priority
pc  out  WIDTH  current fetch address
pc_plus4  out  WIDTH  pc+4 (combinational from pc)
squash  out  1  discard the instruction in IF this cycle
pend  out  1  redirect buffered, waiting for stall release
addr_err  out  1  registered flag: pc[1:0] != 0

Behaviour:
Reset:
- pc=RESET_VECTOR; pend=0, squash=0, addr_err=0; FSM=RUN.

Target arithmetic (combinational, modulo 2^WIDTH):
- BRANCH: redir_base + (sext(imm26[15:0]) << 2).
- JUMP: {redir_base[WIDTH-1:28], imm26, 2'b00}.
- JREG: reg_target.
- ERET: epc.

Priority per edge: rst > exc_valid > redirect > stall hold > sequential.
- exc_valid=1: pc<=EXC_VECTOR regardless of stall, pending buffer cleared, FSM->RUN. squash=1 combinationally that cycle.

FSM states RUN and PEND:
- RUN, redir_valid=1, stall=0: pc<=target; stay RUN.
- RUN, redir_valid=1, stall=1: tgt_buf<=target; pc held; ->PEND.
- RUN, redir_valid=0: pc<=stall ? pc : pc+4.
- PEND, stall=1: pc held. A new redir_valid overwrites tgt_buf (latest wins, since a stalled ID re-presents the same redirect).
- PEND, stall=0: pc<=(redir_valid ? new target : tgt_buf); ->RUN.
- pend = (state==PEND).

Latency:
- Redirect to pc change is one edge when there is no stall.
- ERET is handled as an ordinary redirect: it obeys stall and uses the delay-slot rules below.

Delay slot:
- DELAY_SLOT=1: squash=0 for redirects. The instruction in IF during the redirect cycle is the delay slot and retires.
- DELAY_SLOT=0: squash=redir_valid & ~stall, asserted in the cycle the redirect is applied (including a PEND release).
- squash=1 whenever exc_valid=1, independent of DELAY_SLOT.

Address error:
- addr_err<=(next pc[1:0]!=0), registered alongside pc.
- The PC is still loaded; the exception unit decides what to do.

Wrap-around:
- pc+4 at 32'hFFFF_FFFC wraps to 0 with no flag.

Reset mid-operation:
- rst clears PEND and tgt_buf; any pending redirect is lost.

Decomposition:
- Shared package mips_pkg: redir_kind encodings (RK_BRANCH, RK_JUMP, RK_JREG, RK_ERET), default vectors, WORD_W.
- One natural sub-module, npc_target_calc: purely combinational target mux/adder, parametrised by WIDTH. The top holds the PC register, FSM and buffer.

Test Plan:
- Reset then 3 free cycles -> pc 32'hBFC0_0000, ..._0004, ..._0008, ..._000C; squash=0.
- pc=0x0040_0010, BRANCH, redir_base=0x0040_0014, imm16=0xFFFC, no stall -> next pc=0x0040_0004, squash=0 (DELAY_SLOT=1).
- JUMP, redir_base=0x9000_0004, imm26=0x0100000 -> pc=0x9040_0000. JREG with reg_target=0x0040_0002 -> pc=0x0040_0002, addr_err=1.
- BRANCH arrives with stall=1 for 3 cycles -> pc frozen, pend=1. At release, pc=target and pend=0. With DELAY_SLOT=0, squash pulses exactly in the release cycle.
- exc_valid during PEND with stall=1 -> pc=0xBFC0_0380, pend=0, buffered target discarded; ERET with epc=0x0040_0100 later -> pc=0x0040_0100.
- rst asserted while in PEND -> pc=RESET_VECTOR next edge, pend=0; pc+4 from 0xFFFF_FFFC -> 0x0000_0000.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS front-end constants: redirect kind encodings, default vectors and word width.
package mips_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] RK_BRANCH = 2'd0;
  localparam logic [1:0] RK_JUMP   = 2'd1;
  localparam logic [1:0] RK_JREG   = 2'd2;
  localparam logic [1:0] RK_ERET   = 2'd3;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR_DEF   = 32'hBFC0_0380;

endpackage

// File: rtl/npc_target_calc.sv
// Combinational next-PC target selection for branch, jump, jump-register and ERET redirects.
module npc_target_calc
  import mips_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [1:0]       redir_kind,
  input  logic [WIDTH-1:0] redir_base,
  input  logic [25:0]      imm26,
  input  logic [WIDTH-1:0] reg_target,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] target
);

  logic [WIDTH-1:0] branch_tgt;
  logic [WIDTH-1:0] jump_tgt;

  // Branch offset is the signed 16-bit immediate scaled to a word offset.
  assign branch_tgt = redir_base + {{(WIDTH-18){imm26[15]}}, imm26[15:0], 2'b00};

  generate
    if (WIDTH > 28) begin : g_jump_region
      assign jump_tgt = {redir_base[WIDTH-1:28], imm26, 2'b00};
    end else begin : g_jump_flat
      assign jump_tgt = {imm26, 2'b00};
    end
  endgenerate

  always_comb begin
    target = branch_tgt;
    case (redir_kind)
      RK_BRANCH: target = branch_tgt;
      RK_JUMP:   target = jump_tgt;
      RK_JREG:   target = reg_target;
      RK_ERET:   target = epc;
      default:   target = branch_tgt;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address register with stall hold, redirect buffering across stalls, and exception override.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int               WIDTH        = WORD_W,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(EXC_VECTOR_DEF),
  parameter bit               DELAY_SLOT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redir_valid,
  input  logic [1:0]       redir_kind,
  input  logic [WIDTH-1:0] redir_base,
  input  logic [25:0]      imm26,
  input  logic [WIDTH-1:0] reg_target,
  input  logic [WIDTH-1:0] epc,
  input  logic             exc_valid,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             squash,
  output logic             pend,
  output logic             addr_err
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] tgt_buf_q, tgt_buf_d;
  logic             addr_err_q, addr_err_d;
  logic [WIDTH-1:0] target;
  logic             squash_d;

  npc_target_calc #(.WIDTH(WIDTH)) u_target (
    .redir_kind (redir_kind),
    .redir_base (redir_base),
    .imm26      (imm26),
    .reg_target (reg_target),
    .epc        (epc),
    .target     (target)
  );

  assign pc_plus4 = pc_q + WIDTH'(4);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_buf_d = tgt_buf_q;
    squash_d  = 1'b0;
    if (exc_valid) begin
      pc_d      = EXC_VECTOR;
      tgt_buf_d = '0;
      state_d   = ST_RUN;
      squash_d  = 1'b1;
    end else if (state_q == ST_RUN) begin
      if (redir_valid && !stall) begin
        pc_d     = target;
        squash_d = !DELAY_SLOT;
      end else if (redir_valid) begin
        tgt_buf_d = target;
        state_d   = ST_PEND;
      end else if (!stall) begin
        pc_d = pc_plus4;
      end
    end else begin
      // A stalled ID keeps presenting its redirect, so the newest one wins.
      if (stall) begin
        if (redir_valid) tgt_buf_d = target;
      end else begin
        pc_d     = redir_valid ? target : tgt_buf_q;
        state_d  = ST_RUN;
        squash_d = !DELAY_SLOT;
      end
    end
    addr_err_d = (pc_d[1:0] != 2'b00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VECTOR;
      tgt_buf_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      tgt_buf_q  <= tgt_buf_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign pc       = pc_q;
  assign pend     = (state_q == ST_PEND);
  assign addr_err = addr_err_q;
  assign squash   = squash_d & ~rst;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a second instance with DELAY_SLOT=0 checks squash behaviour.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, redir_valid, exc_valid;
  logic [1:0]  redir_kind;
  logic [31:0] redir_base, reg_target, epc;
  logic [25:0] imm26;
  logic [31:0] pc, pc_plus4, pc_n, pc_plus4_n;
  logic        squash, pend, addr_err, squash_n, pend_n, addr_err_n;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.DELAY_SLOT(1'b1)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid),
    .redir_kind(redir_kind), .redir_base(redir_base), .imm26(imm26),
    .reg_target(reg_target), .epc(epc), .exc_valid(exc_valid),
    .pc(pc), .pc_plus4(pc_plus4), .squash(squash), .pend(pend), .addr_err(addr_err)
  );

  pc_sequencer #(.DELAY_SLOT(1'b0)) dut_nds (
    .clk(clk), .rst(rst), .stall(stall), .redir_valid(redir_valid),
    .redir_kind(redir_kind), .redir_base(redir_base), .imm26(imm26),
    .reg_target(reg_target), .epc(epc), .exc_valid(exc_valid),
    .pc(pc_n), .pc_plus4(pc_plus4_n), .squash(squash_n), .pend(pend_n), .addr_err(addr_err_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    stall = 1'b0; redir_valid = 1'b0; exc_valid = 1'b0;
    redir_kind = 2'd0; redir_base = '0; imm26 = '0; reg_target = '0; epc = '0;
  endtask

  task automatic redir(input logic [1:0] kind, input logic [31:0] base,
                       input logic [25:0] imm, input logic [31:0] rt, input logic [31:0] e);
    redir_valid = 1'b1; redir_kind = kind; redir_base = base;
    imm26 = imm; reg_target = rt; epc = e;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    step(); step();
    checks++; if (pc !== 32'hBFC0_0000) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'hBFC0_0000); end
    checks++; if ({pend, squash, addr_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {pend, squash, addr_err}); end
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      checks++; if (pc !== 32'hBFC0_0000 + 32'(4*i)) begin errors++; $display("FAIL seq_pc%0d: got %h expected %h", i, pc, 32'hBFC0_0000 + 32'(4*i)); end
      checks++; if (squash !== 1'b0) begin errors++; $display("FAIL seq_squash%0d: got %b expected 0", i, squash); end
    end
    checks++; if (pc_plus4 !== 32'hBFC0_0010) begin errors++; $display("FAIL pc_plus4: got %h expected %h", pc_plus4, 32'hBFC0_0010); end
    $display("test_reset: pc=%h", pc);
  endtask

  task automatic test_branch();
    redir(2'd2, '0, '0, 32'h0040_0010, '0); step();
    checks++; if (pc !== 32'h0040_0010) begin errors++; $display("FAIL jreg_setup: got %h expected %h", pc, 32'h0040_0010); end
    redir(2'd0, 32'h0040_0014, 26'h000_FFFC, '0, '0); #1;
    checks++; if (squash !== 1'b0) begin errors++; $display("FAIL branch_squash_ds1: got %b expected 0", squash); end
    checks++; if (squash_n !== 1'b1) begin errors++; $display("FAIL branch_squash_ds0: got %b expected 1", squash_n); end
    step();
    checks++; if (pc !== 32'h0040_0004) begin errors++; $display("FAIL branch_pc: got %h expected %h", pc, 32'h0040_0004); end
    idle(); #1;
    checks++; if (squash_n !== 1'b0) begin errors++; $display("FAIL branch_squash_after: got %b expected 0", squash_n); end
    $display("test_branch: pc=%h", pc);
  endtask

  task automatic test_jump();
    redir(2'd1, 32'h9000_0004, 26'h010_0000, '0, '0); step();
    checks++; if (pc !== 32'h9040_0000) begin errors++; $display("FAIL jump_pc: got %h expected %h", pc, 32'h9040_0000); end
    redir(2'd2, '0, '0, 32'h0040_0002, '0); step();
    checks++; if (pc !== 32'h0040_0002) begin errors++; $display("FAIL jreg_pc: got %h expected %h", pc, 32'h0040_0002); end
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL jreg_addr_err: got %b expected 1", addr_err); end
    redir(2'd2, '0, '0, 32'h0040_0100, '0); step();
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL addr_err_clear: got %b expected 0", addr_err); end
    $display("test_jump: pc=%h", pc);
  endtask

  task automatic test_stall_pend();
    stall = 1'b1;
    redir(2'd0, 32'h0040_0104, 26'h000_0008, '0, '0); step();
    redir_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++; if ({squash, squash_n} !== 2'b00) begin errors++; $display("FAIL stall_squash%0d: got %b expected 00", i, {squash, squash_n}); end
      step();
    end
    checks++; if (pc !== 32'h0040_0100 || pc_n !== 32'h0040_0100) begin errors++; $display("FAIL stall_pc: got %h/%h expected %h", pc, pc_n, 32'h0040_0100); end
    checks++; if (pend !== 1'b1) begin errors++; $display("FAIL stall_pend: got %b expected 1", pend); end
    stall = 1'b0; #1;
    checks++; if (squash_n !== 1'b1) begin errors++; $display("FAIL release_squash_ds0: got %b expected 1", squash_n); end
    checks++; if (squash !== 1'b0) begin errors++; $display("FAIL release_squash_ds1: got %b expected 0", squash); end
    step();
    checks++; if (pc !== 32'h0040_0124 || pc_n !== 32'h0040_0124) begin errors++; $display("FAIL release_pc: got %h/%h expected %h", pc, pc_n, 32'h0040_0124); end
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL release_pend: got %b expected 0", pend); end
    checks++; if (squash_n !== 1'b0) begin errors++; $display("FAIL post_release_squash: got %b expected 0", squash_n); end
    step();
    checks++; if (pc !== 32'h0040_0128) begin errors++; $display("FAIL post_release_pc: got %h expected %h", pc, 32'h0040_0128); end
    $display("test_stall_pend: pc=%h", pc);
  endtask

  task automatic test_exception();
    stall = 1'b1;
    redir(2'd0, 32'h0040_0200, 26'h000_0004, '0, '0); step();
    checks++; if (pend !== 1'b1) begin errors++; $display("FAIL exc_pre_pend: got %b expected 1", pend); end
    redir_valid = 1'b0; exc_valid = 1'b1; #1;
    checks++; if ({squash, squash_n} !== 2'b11) begin errors++; $display("FAIL exc_squash: got %b expected 11", {squash, squash_n}); end
    step();
    checks++; if (pc !== 32'hBFC0_0380) begin errors++; $display("FAIL exc_pc: got %h expected %h", pc, 32'hBFC0_0380); end
    checks++; if (pend !== 1'b0) begin errors++; $display("FAIL exc_pend: got %b expected 0", pend); end
    idle(); step();
    checks++; if (pc !== 32'hBFC0_0384) begin errors++; $display("FAIL exc_discard: got %h expected %h", pc, 32'hBFC0_0384); end
    redir(2'd3, '0, '0, '0, 32'h0040_0100); step();
    checks++; if (pc !== 32'h0040_0100) begin errors++; $display("FAIL eret_pc: got %h expected %h", pc, 32'h0040_0100); end
    idle();
    $display("test_exception: pc=%h", pc);
  endtask

  task automatic test_back_to_back();
    stall = 1'b1;
    redir(2'd2, '0, '0, 32'h0000_1000, '0); step();
    redir(2'd2, '0, '0, 32'h0000_2000, '0); step();
    redir_valid = 1'b0; stall = 1'b0; step();
    checks++; if (pc !== 32'h0000_2000) begin errors++; $display("FAIL latest_wins: got %h expected %h", pc, 32'h0000_2000); end
    stall = 1'b1;
    redir(2'd2, '0, '0, 32'h0000_3000, '0); step();
    stall = 1'b0;
    redir(2'd1, 32'h0000_0004, 26'h000_0400, '0, '0); step();
    checks++; if (pc !== 32'h0000_1000) begin errors++; $display("FAIL release_new_redir: got %h expected %h", pc, 32'h0000_1000); end
    idle();
    $display("test_back_to_back: pc=%h", pc);
  endtask

  task automatic test_reset_in_pend();
    stall = 1'b1;
    redir(2'd2, '0, '0, 32'h1234_5678, '0); step();
    checks++; if (pend !== 1'b1) begin errors++; $display("FAIL rst_pre_pend: got %b expected 1", pend); end
    redir_valid = 1'b0; rst = 1'b1; step();
    checks++; if (pc !== 32'hBFC0_0000 || pend !== 1'b0) begin errors++; $display("FAIL rst_pend: got pc=%h pend=%b expected pc=%h pend=0", pc, pend, 32'hBFC0_0000); end
    rst = 1'b0; stall = 1'b0; step();
    checks++; if (pc !== 32'hBFC0_0004) begin errors++; $display("FAIL rst_lost_redir: got %h expected %h", pc, 32'hBFC0_0004); end
    $display("test_reset_in_pend: pc=%h", pc);
  endtask

  task automatic test_wrap();
    redir(2'd2, '0, '0, 32'hFFFF_FFFC, '0); step();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_setup: got %h expected %h", pc, 32'hFFFF_FFFC); end
    idle(); step();
    checks++; if (pc !== 32'h0000_0000) begin errors++; $display("FAIL wrap_pc: got %h expected %h", pc, 32'h0000_0000); end
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL wrap_addr_err: got %b expected 0", addr_err); end
    $display("test_wrap: pc=%h", pc);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_branch();
    test_jump();
    test_stall_pend();
    test_exception();
    test_back_to_back();
    test_reset_in_pend();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
